// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one request at a time over valid/ready, with a fixed
// programmable latency before a sign/zero-extended load result or store acknowledgement.
module dmem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0100_0000,
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;

  logic [31:0] mem [DEPTH];

  logic [31:0] word_idx;
  logic [AW-1:0] mem_idx;
  logic        in_range;
  logic        misaligned;
  logic        access_err;
  logic [31:0] cur_word;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_data;
  logic [31:0] store_data;
  logic [3:0]  lane_en;
  logic        access_now;
  logic        commit;

  // Addresses below BASE_ADDR wrap to huge indices and fall out of range naturally.
  always_comb begin
    word_idx = (addr_q - BASE_ADDR) >> 2;
    mem_idx  = word_idx[AW-1:0];
    in_range = (word_idx < 32'(DEPTH));
    cur_word = in_range ? mem[mem_idx] : 32'd0;
  end

  always_comb begin
    misaligned = 1'b0;
    case (size_q)
      2'd1:    misaligned = addr_q[0];
      2'd2:    misaligned = (addr_q[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    access_err = !in_range || misaligned || (size_q == 2'd3);
  end

  always_comb begin
    lane_b    = cur_word[{addr_q[1:0], 3'b000} +: 8];
    lane_h    = addr_q[1] ? cur_word[31:16] : cur_word[15:0];
    load_data = 32'd0;
    case (size_q)
      2'd0:    load_data = uns_q ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'd1:    load_data = uns_q ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
      2'd2:    load_data = cur_word;
      default: load_data = 32'd0;
    endcase
  end

  // Store data is replicated across lanes; lane_en picks which lanes are actually written.
  always_comb begin
    store_data = wdata_q;
    lane_en    = 4'b0000;
    case (size_q)
      2'd0: begin
        store_data = {4{wdata_q[7:0]}};
        lane_en    = 4'b0001 << addr_q[1:0];
      end
      2'd1: begin
        store_data = {2{wdata_q[15:0]}};
        lane_en    = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      2'd2: begin
        store_data = wdata_q;
        lane_en    = 4'b1111;
      end
      default: begin
        store_data = wdata_q;
        lane_en    = 4'b0000;
      end
    endcase
  end

  assign access_now = (state == WAIT) && (cnt == 4'd0);
  assign commit     = access_now && we_q && !access_err && !reset;
  assign req_ready  = (state == IDLE) && !reset;

  // Array is deliberately not reset; contents survive a reset pulse.
  always_ff @(posedge clock) begin
    if (commit) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_en[k]) mem[mem_idx][8*k +: 8] <= store_data[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      we_q       <= 1'b0;
      size_q     <= 2'd0;
      uns_q      <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          resp_rdata <= 32'd0;
          resp_err   <= 1'b0;
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            cnt     <= 4'(LATENCY - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= access_err;
            resp_rdata <= (access_err || we_q) ? 32'd0 : load_data;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a table of sequential requests plus hand-written
// sequences for backpressure and reset in the middle of a transaction.
module tb_dmem_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks   = 0;
  int failures = 0;

  dmem_responder #(.BASE_ADDR(32'h0100_0000), .DEPTH(1024), .LATENCY(2)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_valid    = 1'b1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    @(negedge clock);
    while (!req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) check({name, "_ready_timeout"}, 32'(req_ready), 32'd1);
  endtask

  // Full transaction; lat counts sampled cycles after acceptance until resp_valid is seen.
  task automatic run_req(input string name, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat);
    wait_ready(name);
    drive(we, size, uns, addr, wdata);
    @(posedge clock);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!resp_valid && lat < 40);
    rdata = resp_rdata;
    err   = resp_err;
    resp_ready = 1'b1;
    @(posedge clock);
    #1 resp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;

    vecs.push_back('{"st_word",      1, 2'd2, 0, 32'h0100_0010, 32'hDEAD_BEEF, 32'h0000_0000, 0});
    vecs.push_back('{"ld_word",      0, 2'd2, 0, 32'h0100_0010, 32'h0,         32'hDEAD_BEEF, 0});
    vecs.push_back('{"st_byte",      1, 2'd0, 0, 32'h0100_0011, 32'h0000_AB80, 32'h0000_0000, 0});
    vecs.push_back('{"ld_byte_s",    0, 2'd0, 0, 32'h0100_0011, 32'h0,         32'hFFFF_FF80, 0});
    vecs.push_back('{"ld_byte_u",    0, 2'd0, 1, 32'h0100_0011, 32'h0,         32'h0000_0080, 0});
    vecs.push_back('{"ld_word_mix",  0, 2'd2, 0, 32'h0100_0010, 32'h0,         32'hDEAD_80EF, 0});
    vecs.push_back('{"ld_half_s",    0, 2'd1, 0, 32'h0100_0012, 32'h0,         32'hFFFF_DEAD, 0});
    vecs.push_back('{"ld_half_u",    0, 2'd1, 1, 32'h0100_0012, 32'h0,         32'h0000_DEAD, 0});
    vecs.push_back('{"ld_half_mis",  0, 2'd1, 0, 32'h0100_0011, 32'h0,         32'h0000_0000, 1});
    vecs.push_back('{"st_word_mis",  1, 2'd2, 0, 32'h0100_0012, 32'h1111_2222, 32'h0000_0000, 1});
    vecs.push_back('{"ld_word_keep", 0, 2'd2, 0, 32'h0100_0010, 32'h0,         32'hDEAD_80EF, 0});
    vecs.push_back('{"ld_below",     0, 2'd2, 0, 32'h00FF_FFFC, 32'h0,         32'h0000_0000, 1});
    vecs.push_back('{"ld_above",     0, 2'd2, 0, 32'h0100_1000, 32'h0,         32'h0000_0000, 1});
    vecs.push_back('{"ld_size3",     0, 2'd3, 0, 32'h0100_0010, 32'h0,         32'h0000_0000, 1});
    vecs.push_back('{"st_half_lo",   1, 2'd1, 0, 32'h0100_0010, 32'hFFFF_1234, 32'h0000_0000, 0});
    vecs.push_back('{"ld_word_h",    0, 2'd2, 0, 32'h0100_0010, 32'h0,         32'hDEAD_1234, 0});
    vecs.push_back('{"ld_half_lo",   0, 2'd1, 0, 32'h0100_0010, 32'h0,         32'h0000_1234, 0});
    vecs.push_back('{"st_byte3",     1, 2'd0, 0, 32'h0100_0013, 32'h0000_00FE, 32'h0000_0000, 0});
    vecs.push_back('{"ld_byte3_s",   0, 2'd0, 0, 32'h0100_0013, 32'h0,         32'hFFFF_FFFE, 0});
    vecs.push_back('{"ld_byte2_u",   0, 2'd0, 1, 32'h0100_0012, 32'h0,         32'h0000_00AD, 0});
    vecs.push_back('{"ld_word_b3",   0, 2'd2, 0, 32'h0100_0010, 32'h0,         32'hFEAD_1234, 0});
    vecs.push_back('{"st_last",      1, 2'd2, 0, 32'h0100_0FFC, 32'hCAFE_F00D, 32'h0000_0000, 0});
    vecs.push_back('{"ld_last",      0, 2'd2, 0, 32'h0100_0FFC, 32'h0,         32'hCAFE_F00D, 0});
    vecs.push_back('{"st_w20",       1, 2'd2, 0, 32'h0100_0020, 32'hA5A5_A5A5, 32'h0000_0000, 0});

    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    req_addr = '0; req_wdata = '0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;

    // Reset values
    repeat (2) @(negedge clock);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_ready", 32'(req_ready), 32'd1);

    foreach (vecs[i]) begin
      run_req(vecs[i].name, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr,
              vecs[i].wdata, rd, er, lat);
      check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
      check({vecs[i].name, "_err"}, 32'(er), 32'(vecs[i].exp_err));
      check({vecs[i].name, "_lat"}, 32'(lat), 32'd3);
    end

    // Backpressure: response held while a second request waits.
    wait_ready("bp");
    drive(0, 2'd2, 0, 32'h0100_0010, 32'h0);
    @(posedge clock);
    #1 drive(0, 2'd2, 0, 32'h0100_0FFC, 32'h0);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!resp_valid && n < 40);
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", 32'(resp_valid), 32'd1);
      check("bp_rdata", resp_rdata, 32'hFEAD_1234);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      @(negedge clock);
    end
    resp_ready = 1'b1;
    @(posedge clock);
    #1 resp_ready = 1'b0;
    @(negedge clock);
    check("bp_ready_after", 32'(req_ready), 32'd1);
    check("bp_valid_after", 32'(resp_valid), 32'd0);
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    check("bp_second_accepted", 32'(req_ready), 32'd0);
    n = 1;
    while (!resp_valid && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("bp_second_lat", 32'(n), 32'd3);
    check("bp_second_rdata", resp_rdata, 32'hCAFE_F00D);
    resp_ready = 1'b1;
    @(posedge clock);
    #1 resp_ready = 1'b0;

    // Reset during WAIT drops a pending store.
    wait_ready("rw");
    drive(1, 2'd2, 0, 32'h0100_0020, 32'h1234_5678);
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1 check("rw_req_ready", 32'(req_ready), 32'd0);
    @(negedge clock);
    check("rw_resp_valid", 32'(resp_valid), 32'd0);
    check("rw_resp_rdata", resp_rdata, 32'd0);
    check("rw_resp_err", 32'(resp_err), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1 check("rw_ready_after", 32'(req_ready), 32'd1);
    run_req("rw_load", 0, 2'd2, 0, 32'h0100_0020, 32'h0, rd, er, lat);
    check("rw_old_data", rd, 32'hA5A5_A5A5);
    check("rw_old_err", 32'(er), 32'd0);

    // Reset during RESP drops the response.
    wait_ready("rr");
    drive(0, 2'd2, 0, 32'h0100_0010, 32'h0);
    @(posedge clock);
    #1 req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!resp_valid && n < 40);
    check("rr_valid_before", 32'(resp_valid), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("rr_valid_dropped", 32'(resp_valid), 32'd0);
    check("rr_rdata_cleared", resp_rdata, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("rr_no_resp", 32'(resp_valid), 32'd0);
    check("rr_ready", 32'(req_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
